multi_blinker: RTL and testbench

//   Parametrised, multi-channel successor to the single-output blinker.
//   One shared prescaler produces a periodic tick. Each channel has a run-time mode (OFF, ON, BLINK, ONESHOT)
//   and a period in ticks, both loaded through a simple write port.

---
 rtl/multi_blinker.sv | 133 +++++++++++++
 tb/tb_multi_blinker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_blinker.sv
// multi_blinker: multi-channel LED driver with one shared tick prescaler and
// per-channel OFF/ON/BLINK/ONESHOT modes loaded through a single write port.
module multi_blinker #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SPEED    = 24,
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(CHANNELS):0] wr_ch,
    input  logic [1:0]                wr_mode,
    input  logic [PERIOD_W-1:0]       wr_period,
    input  logic                      sync,
    output logic                      tick,
    output logic [CHANNELS-1:0]       led,
    output logic [CHANNELS-1:0]       done
);
    localparam int unsigned CH_W = $clog2(CHANNELS) + 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    logic [SPEED-1:0]    presc_q, presc_d;
    logic                tick_en;

    mode_e               mode_q   [CHANNELS];
    mode_e               mode_d   [CHANNELS];
    logic [PERIOD_W-1:0] period_q [CHANNELS];
    logic [PERIOD_W-1:0] period_d [CHANNELS];
    logic [PERIOD_W-1:0] count_q  [CHANNELS];
    logic [PERIOD_W-1:0] count_d  [CHANNELS];
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] at_end;

    // sync both clears the prescaler and masks the tick it would have produced
    always_comb begin
        tick_en = (&presc_q) & ~sync;
        presc_d = sync ? '0 : presc_q + SPEED'(1);
    end

    // Out-of-range channel indices never match any decode line, so they are dropped here
    always_comb begin
        wr_sel = '0;
        at_end = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = wr_en && (wr_ch == CH_W'(i));
            if (period_q[i] == '0) begin
                at_end[i] = (count_q[i] == '0);
            end else begin
                at_end[i] = (count_q[i] == period_q[i] - PERIOD_W'(1));
            end
        end
    end

    // Priority per channel: write, then sync, then tick
    always_comb begin
        led_d  = led_q;
        done_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];
            if (wr_sel[i]) begin
                mode_d[i]   = mode_e'(wr_mode);
                period_d[i] = wr_period;
                count_d[i]  = '0;
                led_d[i]    = (mode_e'(wr_mode) != MODE_OFF);
            end else if (sync) begin
                count_d[i] = '0;
                if (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_ONESHOT) begin
                    led_d[i] = 1'b1;
                end
            end else if (tick_en) begin
                unique case (mode_q[i])
                    MODE_OFF: led_d[i] = 1'b0;
                    MODE_ON:  led_d[i] = 1'b1;
                    MODE_BLINK: begin
                        if (at_end[i]) begin
                            count_d[i] = '0;
                            led_d[i]   = ~led_q[i];
                        end else begin
                            count_d[i] = count_q[i] + PERIOD_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (at_end[i]) begin
                            count_d[i] = '0;
                            led_d[i]   = 1'b0;
                            mode_d[i]  = MODE_OFF;
                            done_d[i]  = 1'b1;
                        end else begin
                            count_d[i] = count_q[i] + PERIOD_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            led_q   <= '0;
            done_q  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            presc_q <= presc_d;
            led_q   <= led_d;
            done_q  <= done_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    assign tick = tick_en;
    assign led  = led_q;
    assign done = done_q;

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker with SPEED=2 (tick every 4 cycles),
// PERIOD_W=4, CHANNELS=4; expectations are hand-derived edge counts.
module tb_multi_blinker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [3:0] wr_period = '0;
    logic       sync = 1'b0;
    logic       tick;
    logic [3:0] led;
    logic [3:0] done;

    int total = 0;
    int bad   = 0;

    multi_blinker #(
        .CHANNELS(4),
        .SPEED   (2),
        .PERIOD_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_mode  (wr_mode),
        .wr_period(wr_period),
        .sync     (sync),
        .tick     (tick),
        .led      (led),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_write(input logic [2:0] ch, input logic [1:0] mode, input logic [3:0] per);
        wr_en     = 1'b1;
        wr_ch     = ch;
        wr_mode   = mode;
        wr_period = per;
    endtask

    task automatic clear_write();
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_mode   = '0;
        wr_period = '0;
    endtask

    // Leaves the prescaler at 0 just after the sync edge (edge 0)
    task automatic align();
        clear_write();
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sync = 1'b0;
        clear_write();
        #12;
        total++;
        if (led !== 4'b0000 || done !== 4'b0000 || tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_state led=%b done=%b tick=%b want 0000 0000 0", led, done, tick);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            total++;
            if (tick !== (e == 3)) begin
                bad++;
                $display("FAIL first_tick edge=%0d tick=%b want %b", e, tick, (e == 3));
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            set_write(3'(ch), 2'd1, 4'd0);
            @(posedge clk); #1;
        end
        clear_write();
        total++;
        if (led !== 4'b1111) begin
            bad++;
            $display("FAIL all_on led=%b want 1111", led);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (led !== 4'b0000 || done !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset led=%b done=%b want 0000 0000", led, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (led !== 4'b0000) begin
            bad++;
            $display("FAIL after_release led=%b want 0000", led);
        end
    endtask

    task automatic test_blink();
        logic exp;
        align();
        for (int t = 1; t <= 40; t++) begin
            if (t == 1) set_write(3'd0, 2'd2, 4'd3);
            else        clear_write();
            @(posedge clk); #1;
            exp = (t < 12) || ((((t - 12) / 12) % 2) == 1);
            total++;
            if (led[0] !== exp) begin
                bad++;
                $display("FAIL blink_p3 t=%0d led0=%b want %b", t, led[0], exp);
            end
            total++;
            if (tick !== ((t % 4) == 3)) begin
                bad++;
                $display("FAIL blink_tick t=%0d tick=%b want %b", t, tick, ((t % 4) == 3));
            end
        end
    endtask

    task automatic test_oneshot();
        align();
        for (int t = 1; t <= 16; t++) begin
            if (t == 1) set_write(3'd1, 2'd3, 4'd2);
            else        clear_write();
            @(posedge clk); #1;
            total++;
            if (led[1] !== (t < 8)) begin
                bad++;
                $display("FAIL oneshot_led t=%0d led1=%b want %b", t, led[1], (t < 8));
            end
            total++;
            if (done[1] !== (t == 8)) begin
                bad++;
                $display("FAIL oneshot_done t=%0d done1=%b want %b", t, done[1], (t == 8));
            end
        end
        // A sync relights ONESHOT channels, so staying dark proves the mode fell back to OFF
        align();
        total++;
        if (led[1] !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_mode_off led1=%b want 0", led[1]);
        end
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            total++;
            if (led[1] !== 1'b0 || done !== 4'b0000) begin
                bad++;
                $display("FAIL oneshot_idle t=%0d led1=%b done=%b want 0 0000", t, led[1], done);
            end
        end
    endtask

    task automatic test_zero_period();
        logic [3:0] exp;
        align();
        for (int t = 1; t <= 16; t++) begin
            if (t == 1)      set_write(3'd2, 2'd2, 4'd0);
            else if (t == 5) set_write(3'd5, 2'd1, 4'd15);
            else if (t == 6) set_write(3'd4, 2'd1, 4'd0);
            else             clear_write();
            @(posedge clk); #1;
            exp = {1'b0, (((t / 4) % 2) == 0), 1'b0, (t < 12)};
            total++;
            if (led !== exp || done !== 4'b0000) begin
                bad++;
                $display("FAIL zero_period_oob t=%0d led=%b done=%b want %b 0000", t, led, done, exp);
            end
        end
    endtask

    task automatic test_sync();
        logic b;
        align();
        for (int t = 1; t <= 19; t++) begin
            if (t == 1)      set_write(3'd0, 2'd2, 4'd2);
            else if (t == 2) set_write(3'd2, 2'd0, 4'd0);
            else if (t == 5) set_write(3'd3, 2'd2, 4'd2);
            else             clear_write();
            @(posedge clk); #1;
            if (t == 17) begin
                total++;
                if (led !== 4'b0001) begin
                    bad++;
                    $display("FAIL sync_phase_before led=%b want 0001", led);
                end
            end
        end
        total++;
        if (tick !== 1'b1) begin
            bad++;
            $display("FAIL sync_pre_tick tick=%b want 1", tick);
        end
        sync = 1'b1;
        #1;
        total++;
        if (tick !== 1'b0) begin
            bad++;
            $display("FAIL sync_tick_suppress tick=%b want 0", tick);
        end
        @(posedge clk); #1;
        sync = 1'b0;
        total++;
        if (led !== 4'b1001) begin
            bad++;
            $display("FAIL sync_relight led=%b want 1001", led);
        end
        for (int s = 1; s <= 20; s++) begin
            @(posedge clk); #1;
            b = (((s / 8) % 2) == 0);
            total++;
            if (led !== {b, 2'b00, b}) begin
                bad++;
                $display("FAIL sync_lockstep s=%0d led=%b want %b", s, led, {b, 2'b00, b});
            end
            total++;
            if (tick !== ((s % 4) == 3)) begin
                bad++;
                $display("FAIL sync_prescaler s=%0d tick=%b want %b", s, tick, ((s % 4) == 3));
            end
        end
    endtask

    task automatic test_write_wins();
        logic b;
        align();
        for (int s = 1; s <= 20; s++) begin
            if (s == 8) set_write(3'd0, 2'd1, 4'd2);
            else        clear_write();
            @(posedge clk); #1;
            b = (((s / 8) % 2) == 0);
            total++;
            if (led !== {b, 2'b00, 1'b1} || done !== 4'b0000) begin
                bad++;
                $display("FAIL write_wins s=%0d led=%b done=%b want %b 0000", s, led, done, {b, 2'b00, 1'b1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_oneshot();
        test_zero_period();
        test_sync();
        test_write_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
